// File: rtl/obi_arb_pkg.sv
// Shared types and the arbitration policy helper for the OBI instruction/data arbiter.
package obi_arb_pkg;

  typedef enum logic {PORT_I = 1'b0, PORT_D = 1'b1} port_id_e;

  typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_e;

  // Picks the winner among the current requesters. On contention, round-robin
  // favours the port that did not win last, fixed priority always favours D.
  // With no requester the result is unused; PORT_I is returned.
  function automatic port_id_e arb_pick(input logic     i_req,
                                        input logic     d_req,
                                        input port_id_e last_win,
                                        input logic     rr_en);
    port_id_e pick;
    pick = PORT_I;
    if (i_req && d_req) begin
      if (rr_en) begin
        pick = (last_win == PORT_I) ? PORT_D : PORT_I;
      end else begin
        pick = PORT_D;
      end
    end else if (d_req) begin
      pick = PORT_D;
    end
    return pick;
  endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order FIFO of port IDs for accepted-but-unanswered transactions.
// Push is ignored when full and pop is ignored when empty.
module obi_arb_id_fifo
  import obi_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  port_id_e push_id_i,
  input  logic     pop_i,
  output logic     full_o,
  output logic     empty_o,
  output port_id_e head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  port_id_e         r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign head_o  = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ID storage written at the tail on every accepted push.
  // NOTE: storage is not reset; entries are only read while r_count says they are valid.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= push_id_i;
  end

endmodule

// File: rtl/obi_sram_arbiter.sv
// 2:1 OBI arbiter merging the instruction (i_) and data (d_) ports onto one SRAM port.
// Responses are routed back in issue order using an ID FIFO.
// Define ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority.
module obi_sram_arbiter
  import obi_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  output logic              i_gnt_o,
  input  logic [ADDR_W-1:0] i_addr_i,
  input  logic              i_we_i,
  input  logic [DATA_W/8-1:0] i_be_i,
  input  logic [DATA_W-1:0] i_wdata_i,
  output logic              i_rvalid_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic              d_req_i,
  output logic              d_gnt_o,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic              d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              m_req_o,
  input  logic              m_gnt_i,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic              m_we_o,
  output logic [DATA_W/8-1:0] m_be_o,
  output logic [DATA_W-1:0] m_wdata_o,
  input  logic              m_rvalid_i,
  input  logic [DATA_W-1:0] m_rdata_i,
  output logic              resp_err_o
);

`ifdef ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  port_id_e   r_last_win;
  port_id_e   r_held_id;
  logic       r_resp_err;

  port_id_e   w_pick;
  port_id_e   w_sel;
  port_id_e   w_head;
  logic       w_held_req;
  logic       w_handshake;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;

  assign w_pick      = arb_pick(i_req_i, d_req_i, r_last_win, RR_EN);
  assign w_held_req  = (r_held_id == PORT_I) ? i_req_i : d_req_i;
  assign m_req_o     = (i_req_i | d_req_i) & ~w_full;
  assign w_handshake = m_req_o & m_gnt_i;

  // Request fields follow the selected port with no added latency.
  assign m_addr_o  = (w_sel == PORT_D) ? d_addr_i  : i_addr_i;
  assign m_we_o    = (w_sel == PORT_D) ? d_we_i    : i_we_i;
  assign m_be_o    = (w_sel == PORT_D) ? d_be_i    : i_be_i;
  assign m_wdata_o = (w_sel == PORT_D) ? d_wdata_i : i_wdata_i;

  // Responses pop the head ID and are steered to its owner only.
  assign w_pop      = m_rvalid_i & ~w_empty;
  assign i_rvalid_o = w_pop & (w_head == PORT_I);
  assign d_rvalid_o = w_pop & (w_head == PORT_D);
  assign i_rdata_o  = m_rdata_i;
  assign d_rdata_o  = m_rdata_i;
  assign resp_err_o = r_resp_err;

  // Selection, grant steering and next-state: a pending ungranted request freezes the winner.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_sel       = w_pick;
    w_state_nxt = ARB_IDLE;
    i_gnt_o     = 1'b0;
    d_gnt_o     = 1'b0;
    case (r_state)
      ARB_IDLE: w_sel = w_pick;
      // A held port that withdraws its request is a protocol violation; fall back to policy.
      ARB_HOLD: w_sel = w_held_req ? r_held_id : w_pick;
      default:  w_sel = w_pick;
    endcase
    if (m_req_o && !m_gnt_i) w_state_nxt = ARB_HOLD;
    if (w_handshake) begin
      if (w_sel == PORT_I) i_gnt_o = 1'b1;
      else                 d_gnt_o = 1'b1;
    end
  end

  // State, held winner, last winner and the sticky spurious-response flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ARB_IDLE;
      r_held_id  <= PORT_I;
      r_last_win <= PORT_I;
      r_resp_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (m_req_o && !m_gnt_i) r_held_id  <= w_sel;
      if (w_handshake)         r_last_win <= w_sel;
      if (m_rvalid_i && w_empty) r_resp_err <= 1'b1;
    end
  end

  obi_arb_id_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (w_handshake),
    .push_id_i (w_sel),
    .pop_i     (w_pop),
    .full_o    (w_full),
    .empty_o   (w_empty),
    .head_o    (w_head)
  );

endmodule

// File: tb/tb_obi_sram_arbiter.sv
// Self-checking bench for obi_sram_arbiter. Expected responses (owner port and data) are
// queued when a request is granted and compared when the downstream response is returned.
module tb_obi_sram_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        i_req_i, d_req_i, i_we_i, d_we_i, m_gnt_i, m_rvalid_i;
  logic [31:0] i_addr_i, d_addr_i, i_wdata_i, d_wdata_i, m_rdata_i;
  logic [3:0]  i_be_i, d_be_i;
  logic        i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o, m_req_o, m_we_o, resp_err_o;
  logic [31:0] i_rdata_o, d_rdata_o, m_addr_o, m_wdata_o;
  logic [3:0]  m_be_o;

  typedef struct {
    logic        port;  // 0 = I, 1 = D
    logic [31:0] data;
  } exp_t;

  exp_t        pend_q[$];
  logic [31:0] mem [logic [31:0]];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk_i = ~clk_i;

  obi_sram_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_gnt_o(i_gnt_o), .i_addr_i(i_addr_i), .i_we_i(i_we_i),
    .i_be_i(i_be_i), .i_wdata_i(i_wdata_i), .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
    .d_req_i(d_req_i), .d_gnt_o(d_gnt_o), .d_addr_i(d_addr_i), .d_we_i(d_we_i),
    .d_be_i(d_be_i), .d_wdata_i(d_wdata_i), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .m_req_o(m_req_o), .m_gnt_i(m_gnt_i), .m_addr_o(m_addr_o), .m_we_o(m_we_o),
    .m_be_o(m_be_o), .m_wdata_o(m_wdata_o), .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i),
    .resp_err_o(resp_err_o)
  );

  task automatic clr();
    i_req_i = 0; d_req_i = 0; i_we_i = 0; d_we_i = 0; m_gnt_i = 0; m_rvalid_i = 0;
    i_addr_i = 0; d_addr_i = 0; i_wdata_i = 0; d_wdata_i = 0; m_rdata_i = 0;
    i_be_i = 4'hF; d_be_i = 4'hF;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    clr();
    rst_i = 1'b1;
    pend_q.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Drives the next downstream response from the pending queue; ok=0 if nothing is pending.
  task automatic load_resp(output logic port, output logic [31:0] data, output logic ok);
    exp_t e;
    ok = 1'b0; port = 1'b0; data = '0;
    if (pend_q.size() > 0) begin
      e = pend_q.pop_front();
      port = e.port; data = e.data; ok = 1'b1;
      m_rvalid_i = 1'b1;
      m_rdata_i  = data;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk_i); clr(); #1;
    n_checks++;
    if ({m_req_o, i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o, resp_err_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 000000",
               {m_req_o, i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o, resp_err_o});
    end
  endtask

  task automatic test_single();
    logic p, ok; logic [31:0] dat;
    do_reset();
    // write 69 to 0xC
    @(negedge clk_i); clr();
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'hC; d_wdata_i = 32'd69; d_be_i = 4'hF; m_gnt_i = 1;
    #1;
    n_checks++;
    if (d_gnt_o !== 1'b1 || i_gnt_o !== 1'b0) begin
      n_fail++; $display("FAIL single_wr_gnt: got d=%b i=%b want d=1 i=0", d_gnt_o, i_gnt_o);
    end
    n_checks++;
    if (m_addr_o !== 32'hC || m_we_o !== 1'b1 || m_wdata_o !== 32'd69 || m_be_o !== 4'hF) begin
      n_fail++;
      $display("FAIL single_wr_fields: got addr=%h we=%b wd=%0d be=%h want C 1 69 F",
               m_addr_o, m_we_o, m_wdata_o, m_be_o);
    end
    mem[32'hC] = 32'd69;
    pend_q.push_back('{1'b1, 32'h0});
    // write response
    @(negedge clk_i); clr(); load_resp(p, dat, ok); #1;
    n_checks++;
    if (!ok || d_rvalid_o !== 1'b1 || i_rvalid_o !== 1'b0) begin
      n_fail++; $display("FAIL single_wr_resp: got d=%b i=%b want d=1 i=0", d_rvalid_o, i_rvalid_o);
    end
    // read 0xC
    @(negedge clk_i); clr(); d_req_i = 1; d_addr_i = 32'hC; m_gnt_i = 1; #1;
    n_checks++;
    if (d_gnt_o !== 1'b1 || m_we_o !== 1'b0) begin
      n_fail++; $display("FAIL single_rd_gnt: got gnt=%b we=%b want 1 0", d_gnt_o, m_we_o);
    end
    pend_q.push_back('{1'b1, mem[32'hC]});
    @(negedge clk_i); clr(); load_resp(p, dat, ok); #1;
    n_checks++;
    if (!ok || d_rvalid_o !== 1'b1 || i_rvalid_o !== 1'b0 || d_rdata_o !== 32'd69) begin
      n_fail++;
      $display("FAIL single_rd_resp: got d=%b i=%b data=%0d want 1 0 69", d_rvalid_o, i_rvalid_o, d_rdata_o);
    end
  endtask

  task automatic test_contention();
    logic p, ok, exp_d; logic [31:0] dat;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i); clr();
      i_req_i = 1; i_addr_i = 32'h100; d_req_i = 1; d_addr_i = 32'h200; m_gnt_i = 1; #1;
`ifdef ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      n_checks++;
      if (d_gnt_o !== exp_d || i_gnt_o !== !exp_d || m_addr_o !== (exp_d ? 32'h200 : 32'h100)) begin
        n_fail++;
        $display("FAIL contention_gnt%0d: got d=%b i=%b addr=%h want d=%b", k, d_gnt_o, i_gnt_o, m_addr_o, exp_d);
      end
      pend_q.push_back('{exp_d, 32'h5000 + k});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i); clr(); load_resp(p, dat, ok); #1;
      n_checks++;
      if (!ok || i_rvalid_o !== !p || d_rvalid_o !== p || (p ? d_rdata_o : i_rdata_o) !== dat) begin
        n_fail++;
        $display("FAIL contention_resp%0d: got i=%b d=%b want owner=%b data=%h", k, i_rvalid_o, d_rvalid_o, p, dat);
      end
    end
  endtask

  task automatic test_hold();
    logic p, ok; logic [31:0] dat;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i); clr();
      i_req_i = 1; i_addr_i = 32'h40;
      if (k >= 1) begin d_req_i = 1; d_addr_i = 32'h80; end
      #1;
      n_checks++;
      if (m_req_o !== 1'b1 || m_addr_o !== 32'h40 || i_gnt_o !== 1'b0 || d_gnt_o !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cyc%0d: got req=%b addr=%h gi=%b gd=%b want 1 40 0 0", k, m_req_o, m_addr_o, i_gnt_o, d_gnt_o);
      end
    end
    @(negedge clk_i); clr();
    i_req_i = 1; i_addr_i = 32'h40; d_req_i = 1; d_addr_i = 32'h80; m_gnt_i = 1; #1;
    n_checks++;
    if (i_gnt_o !== 1'b1 || d_gnt_o !== 1'b0 || m_addr_o !== 32'h40) begin
      n_fail++; $display("FAIL hold_release: got gi=%b gd=%b addr=%h want 1 0 40", i_gnt_o, d_gnt_o, m_addr_o);
    end
    pend_q.push_back('{1'b0, 32'h11});
    @(negedge clk_i); clr(); d_req_i = 1; d_addr_i = 32'h80; m_gnt_i = 1; #1;
    n_checks++;
    if (d_gnt_o !== 1'b1 || i_gnt_o !== 1'b0 || m_addr_o !== 32'h80) begin
      n_fail++; $display("FAIL hold_next_d: got gd=%b gi=%b addr=%h want 1 0 80", d_gnt_o, i_gnt_o, m_addr_o);
    end
    pend_q.push_back('{1'b1, 32'h22});
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i); clr(); load_resp(p, dat, ok); #1;
      n_checks++;
      if (!ok || i_rvalid_o !== !p || d_rvalid_o !== p || (p ? d_rdata_o : i_rdata_o) !== dat) begin
        n_fail++;
        $display("FAIL hold_resp%0d: got i=%b d=%b want owner=%b data=%h", k, i_rvalid_o, d_rvalid_o, p, dat);
      end
    end
  endtask

  task automatic test_ordering();
    logic p, ok; logic [31:0] dat;
    do_reset();
    @(negedge clk_i); clr(); i_req_i = 1; i_addr_i = 32'h100; m_gnt_i = 1; #1;
    n_checks++;
    if (i_gnt_o !== 1'b1) begin n_fail++; $display("FAIL order_gnt_i0: got %b want 1", i_gnt_o); end
    pend_q.push_back('{1'b0, 32'hA});
    // D issue and the first response in the same cycle
    @(negedge clk_i); clr(); d_req_i = 1; d_addr_i = 32'h200; m_gnt_i = 1; load_resp(p, dat, ok); #1;
    n_checks++;
    if (d_gnt_o !== 1'b1 || !ok || i_rvalid_o !== 1'b1 || d_rvalid_o !== 1'b0 || i_rdata_o !== 32'hA) begin
      n_fail++;
      $display("FAIL order_push_pop: got gd=%b ri=%b rd=%b data=%h want 1 1 0 a", d_gnt_o, i_rvalid_o, d_rvalid_o, i_rdata_o);
    end
    pend_q.push_back('{1'b1, 32'hB});
    @(negedge clk_i); clr(); i_req_i = 1; i_addr_i = 32'h104; m_gnt_i = 1; #1;
    n_checks++;
    if (i_gnt_o !== 1'b1 || m_addr_o !== 32'h104) begin
      n_fail++; $display("FAIL order_gnt_i1: got %b addr=%h want 1 104", i_gnt_o, m_addr_o);
    end
    pend_q.push_back('{1'b0, 32'hC});
    @(negedge clk_i); clr(); #1;
    n_checks++;
    if (m_req_o !== 1'b0 || i_rvalid_o !== 1'b0 || d_rvalid_o !== 1'b0) begin
      n_fail++; $display("FAIL order_idle: got req=%b ri=%b rd=%b want 0 0 0", m_req_o, i_rvalid_o, d_rvalid_o);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i); clr(); load_resp(p, dat, ok); #1;
      n_checks++;
      if (!ok || i_rvalid_o !== !p || d_rvalid_o !== p || (p ? d_rdata_o : i_rdata_o) !== dat) begin
        n_fail++;
        $display("FAIL order_resp%0d: got i=%b d=%b want owner=%b data=%h", k, i_rvalid_o, d_rvalid_o, p, dat);
      end
    end
  endtask

  task automatic test_full();
    logic p, ok; logic [31:0] dat;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i); clr(); d_req_i = 1; d_addr_i = 32'(k * 4); m_gnt_i = 1; #1;
      n_checks++;
      if (d_gnt_o !== 1'b1) begin n_fail++; $display("FAIL full_fill%0d: got %b want 1", k, d_gnt_o); end
      pend_q.push_back('{1'b1, 32'h70 + k});
    end
    @(negedge clk_i); clr(); d_req_i = 1; i_req_i = 1; m_gnt_i = 1; #1;
    n_checks++;
    if (m_req_o !== 1'b0 || d_gnt_o !== 1'b0 || i_gnt_o !== 1'b0) begin
      n_fail++; $display("FAIL full_stall: got req=%b gd=%b gi=%b want 0 0 0", m_req_o, d_gnt_o, i_gnt_o);
    end
    @(negedge clk_i); clr(); d_req_i = 1; m_gnt_i = 1; load_resp(p, dat, ok); #1;
    n_checks++;
    if (m_req_o !== 1'b0 || d_gnt_o !== 1'b0 || !ok || d_rvalid_o !== 1'b1 || d_rdata_o !== dat) begin
      n_fail++;
      $display("FAIL full_no_bypass: got req=%b gd=%b rd=%b data=%h want 0 0 1 %h", m_req_o, d_gnt_o, d_rvalid_o, d_rdata_o, dat);
    end
    @(negedge clk_i); clr(); d_req_i = 1; d_addr_i = 32'h300; m_gnt_i = 1; #1;
    n_checks++;
    if (m_req_o !== 1'b1 || d_gnt_o !== 1'b1) begin
      n_fail++; $display("FAIL full_resume: got req=%b gd=%b want 1 1", m_req_o, d_gnt_o);
    end
    pend_q.push_back('{1'b1, 32'h55});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i); clr(); load_resp(p, dat, ok); #1;
      n_checks++;
      if (!ok || i_rvalid_o !== !p || d_rvalid_o !== p || (p ? d_rdata_o : i_rdata_o) !== dat) begin
        n_fail++;
        $display("FAIL full_drain%0d: got i=%b d=%b data=%h want owner=%b data=%h", k, i_rvalid_o, d_rvalid_o, d_rdata_o, p, dat);
      end
    end
  endtask

  task automatic test_spurious();
    do_reset();
    @(negedge clk_i); clr(); m_rvalid_i = 1; m_rdata_i = 32'hDEAD; #1;
    n_checks++;
    if (i_rvalid_o !== 1'b0 || d_rvalid_o !== 1'b0) begin
      n_fail++; $display("FAIL spur_no_rvalid: got i=%b d=%b want 0 0", i_rvalid_o, d_rvalid_o);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i); clr(); #1;
      n_checks++;
      if (resp_err_o !== 1'b1) begin n_fail++; $display("FAIL spur_sticky%0d: got %b want 1", k, resp_err_o); end
    end
    // reset with a transaction in flight, then the late response
    @(negedge clk_i); clr(); i_req_i = 1; m_gnt_i = 1; #1;
    do_reset();
    #1;
    n_checks++;
    if (resp_err_o !== 1'b0) begin n_fail++; $display("FAIL spur_cleared: got %b want 0", resp_err_o); end
    @(negedge clk_i); clr(); m_rvalid_i = 1; #1;
    n_checks++;
    if (i_rvalid_o !== 1'b0 || d_rvalid_o !== 1'b0) begin
      n_fail++; $display("FAIL late_no_rvalid: got i=%b d=%b want 0 0", i_rvalid_o, d_rvalid_o);
    end
    @(negedge clk_i); clr(); #1;
    n_checks++;
    if (resp_err_o !== 1'b1) begin n_fail++; $display("FAIL late_err: got %b want 1", resp_err_o); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    test_reset();
    test_single();
    test_contention();
    test_hold();
    test_ordering();
    test_full();
    test_spurious();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
